// File: rtl/montgomery_exit.sv
// montgomery_exit: converts a residue out of the Montgomery domain.
// Computes result = in_a * 2^-N_BITS mod in_m by bit-serial REDC with
// multiplier 1, using a W-bit word-serial adder/subtractor.
// Optional feature macro: MONT_EXIT_SKIP_EN -- iterations whose low
// accumulator bit is 0 bypass the word-serial add (data-dependent latency).
module montgomery_exit #(
  parameter int N_BITS = 1024,
  parameter int W      = 64
) (
  input  logic              clk,
  input  logic              resetn,   // active-high synchronous reset
  input  logic              start,
  input  logic [N_BITS-1:0] in_a,
  input  logic [N_BITS-1:0] in_m,
  output logic [N_BITS-1:0] result,
  output logic              busy,
  output logic              done
);

  localparam int K  = N_BITS / W;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_SUB,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [N_BITS:0]   c_q, c_d;        // accumulator, one guard bit
  logic [N_BITS-1:0] d_q, d_d;        // shadow for C - N
  logic [N_BITS-1:0] nr_q, nr_d;      // latched modulus
  logic [N_BITS-1:0] result_q, result_d;
  logic [IW-1:0]     i_q, i_d;        // iteration counter
  logic [KW-1:0]     k_q, k_d;        // word index
  logic              cy_q, cy_d;      // carry (ADD) or borrow (SUB)
  logic              odd_q, odd_d;    // add-N flag for the current iteration

  // Word-slice helpers
  int unsigned       word_pos;
  logic [N_BITS-1:0] word_mask;
  logic [W-1:0]      c_word;
  logic [W-1:0]      nr_word;
  logic              cy_in;
  logic [W:0]        add_sum;
  logic [W:0]        sub_dif;
  logic              last_word;
  logic              final_borrow;

  // Next-state and datapath: one W-bit word per cycle in ADD and SUB
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    nr_d     = nr_q;
    result_d = result_q;
    i_d      = i_q;
    k_d      = k_q;
    cy_d     = cy_q;
    odd_d    = odd_q;

    word_pos  = 32'(k_q) * W;
    word_mask = N_BITS'({W{1'b1}}) << word_pos;
    c_word    = W'(c_q[N_BITS-1:0] >> word_pos);
    nr_word   = W'(nr_q >> word_pos);
    // Carry/borrow chain always starts clean at word 0
    cy_in     = (k_q == '0) ? 1'b0 : cy_q;
    add_sum   = {1'b0, c_word} + {1'b0, (odd_q ? nr_word : {W{1'b0}})} + {{W{1'b0}}, cy_in};
    sub_dif   = {1'b0, c_word} - {1'b0, nr_word} - {{W{1'b0}}, cy_in};
    last_word = (k_q == KW'(K - 1));
    // A set guard bit means C exceeds N, so no real borrow in that case
    final_borrow = sub_dif[W] & ~c_q[N_BITS];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          c_d   = {1'b0, in_a};
          nr_d  = in_m;
          i_d   = '0;
          k_d   = '0;
          cy_d  = 1'b0;
          odd_d = in_a[0];
`ifdef MONT_EXIT_SKIP_EN
          state_d = in_a[0] ? S_ADD : S_SHIFT;
`else
          state_d = S_ADD;
`endif
        end
      end

      S_ADD: begin
        c_d[N_BITS-1:0] = (c_q[N_BITS-1:0] & ~word_mask) |
                          (N_BITS'(add_sum[W-1:0]) << word_pos);
        cy_d = add_sum[W];
        if (last_word) begin
          c_d[N_BITS] = add_sum[W];
          k_d         = '0;
          state_d     = S_SHIFT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_SHIFT: begin
        c_d   = c_q >> 1;
        i_d   = i_q + 1'b1;
        odd_d = c_q[1];
        k_d   = '0;
        cy_d  = 1'b0;
        if (i_q == IW'(N_BITS - 1)) begin
          state_d = S_SUB;
        end else begin
`ifdef MONT_EXIT_SKIP_EN
          state_d = c_q[1] ? S_ADD : S_SHIFT;
`else
          state_d = S_ADD;
`endif
        end
      end

      S_SUB: begin
        d_d  = (d_q & ~word_mask) | (N_BITS'(sub_dif[W-1:0]) << word_pos);
        cy_d = sub_dif[W];
        if (last_word) begin
          // C <= N here, so one conditional subtraction lands in [0, N)
          result_d = final_borrow ? c_q[N_BITS-1:0] : d_d;
          k_d      = '0;
          state_d  = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_DONE: begin
        // start is deliberately not sampled here
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      d_q      <= '0;
      nr_q     <= '0;
      result_q <= '0;
      i_q      <= '0;
      k_q      <= '0;
      cy_q     <= 1'b0;
      odd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      nr_q     <= nr_d;
      result_q <= result_d;
      i_q      <= i_d;
      k_q      <= k_d;
      cy_q     <= cy_d;
      odd_q    <= odd_d;
    end
  end

  assign result = result_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

endmodule

// File: doc/montgomery_exit.md
# montgomery_exit

Converts a residue out of the Montgomery domain: given Ã = A·R mod N (R = 2^N_BITS), it computes A = Ã·R⁻¹ mod N by bit-serial Montgomery reduction (REDC with multiplier 1). The exponentiation datapath encodes its operands with a multiply by R² mod N; this block is the matching decoder applied to the final accumulator before the result leaves the core. It uses a word-serial adder, so area stays small, and it has a start/done handshake compatible with the multiplier units.

## Interface
- N_BITS, 1024: operand width; R = 2^N_BITS.
- W, 64: adder word width; N_BITS must be a multiple of W; K = N_BITS/W.
- clk  input  1  clock, rising edge.
- resetn  input  1  synchronous reset, active-high (1 = reset); the port name is kept for codebase compatibility.
- start  input  1  one-cycle request, sampled only in IDLE.
- in_a  input  N_BITS  Ã, any value < 2^N_BITS; latched on accepted start.
- in_m  input  N_BITS  modulus N, odd, > 1; latched on accepted start.
- result  output  N_BITS  A = Ã·R⁻¹ mod N, in [0, N); valid from done until next accepted start.
- busy  output  1  high from the cycle after an accepted start through the DONE state.
- done  output  1  one-cycle pulse; result valid.

## Operation
- Registers:
  - C, N_BITS+1 bits: accumulator.
  - Nr: latched modulus.
  - i: iteration counter, 0..N_BITS-1.
  - k: word index, 0..K-1.
  - cy: carry/borrow bit.
  - odd: flag latched per iteration.
- IDLE: on start, set C ← {0, in_a}, Nr ← in_m, i ← 0, then go to ADD. In the same transition, odd ← in_a[0] and k ← 0.
- ADD, K cycles: word k computes {cy, C[kW+:W]} ← C[kW+:W] + (odd ? Nr[kW+:W] : 0) + cy. cy is 0 at k = 0. On k = K-1, the carry-out goes to C[N_BITS], then the FSM moves to SHIFT.
- SHIFT, 1 cycle: C ← C >> 1, i ← i+1, and odd is relatched from the new C[0] (C[1] before the shift). If i was N_BITS-1, go to SUB; otherwise go to ADD with k ← 0.
- Invariant: C < 2^N_BITS + N, so the N_BITS+1 bit width never overflows. After N_BITS iterations, C ≤ N.
- SUB, K cycles: word-serial D ← C - {0, Nr}, held in a shadow register; cy is the borrow.
- SUB result select: at the end of SUB, if there is no borrow, result ← D[N_BITS-1:0]. Otherwise result ← C[N_BITS-1:0]. Then go to DONE.
- DONE, 1 cycle: done = 1, then return to IDLE.
- Handshake:
  - start while busy is ignored; there is no queueing.
  - start in the DONE cycle is also ignored.
  - start in IDLE on the cycle after DONE is accepted.
  - in_a and in_m may change freely after the start cycle.
- Reset:
  - Reset values: state = IDLE; result = 0, busy = 0, done = 0; C, D, Nr, i, k, cy and odd are all cleared.
  - Reset mid-operation aborts immediately. No done pulse is produced.
  - Reset has priority over start in the same cycle.
- Arithmetic is unsigned throughout. Behaviour for even N, or N ≤ 1, is unspecified; the bench must not drive it.

## Timing
- Let start be accepted at edge t0.
- Without the macro, done is high in the cycle after edge t0 + N_BITS·(K+1) + K. Total latency L = N_BITS·(K+1) + K + 1 cycles, independent of data.
  - Default parameters: L = 1024·17 + 17 = 17425 cycles.
- busy rises at t0 and falls at the edge ending DONE. done coincides with the last busy cycle.
- result updates on the edge entering DONE. It is stable while done is high and afterwards.

## Configuration
- MONT_EXIT_SKIP_EN defined: in SHIFT, if the newly latched odd = 0, the next iteration bypasses ADD and goes directly to SHIFT, costing 1 cycle instead of K+1.
  - Latency becomes L = Σ(per-iteration cost) + K + 1, where the cost is K+1 for an iteration with odd = 1 and 1 for an iteration with odd = 0.
  - result is unchanged.
- MONT_EXIT_SKIP_EN undefined: latency is fixed as given in Timing, giving a constant-time operation.

## Test plan
- Bench config N_BITS=8, W=4, N=13 (R mod 13 = 9, R⁻¹ mod 13 = 3):
  - in_a=9 → result=1.
  - in_a=6 → result=5.
  - in_a=255 → result=11.
  - With the macro off, done arrives exactly 27 cycles after start in every case.
- in_a=in_m=13 → result=0. This exercises the final subtraction path (C = N before SUB).
- in_a=0 → result=0.
  - With MONT_EXIT_SKIP_EN: done 11 cycles after start.
  - Without the macro: done 27 cycles after start.
- Handshake:
  - A second start pulse at cycle 5 of a run is ignored; result and done timing match the single-start run.
  - start in the DONE cycle is ignored; start the next cycle is accepted.
- Assert resetn at cycle 10 of a run, then release it and start with in_a=9:
  - During reset, busy=0, done=0 and result=0.
  - No done pulse appears for the aborted run.
  - The new run returns 1.
- Default N_BITS=1024, W=64, with N a random odd 1024-bit value:
  - in_a = 2^1024 mod N → result 1.
  - in_a = random x·2^1024 mod N → result x (x < N).
  - Latency is 17425 cycles with the macro off.
